// File: rtl/dcf77_sync_ctrl.sv
// DCF77 sync controller: frame qualification, lock FSM,
// local BCD time-of-day with 1 s divider and holdover.
module dcf77_sync_ctrl #(
    parameter int CLK_HZ       = 24_000_000,
    parameter int HOLDOVER_MIN = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_stb,
    input  logic [58:0] frame_data,
    input  logic        frame_err,
    output logic [6:0]  sec,
    output logic [6:0]  min,
    output logic [5:0]  hour,
    output logic [21:0] date,
    output logic        sec_tick,
    output logic [1:0]  state,
    output logic        time_valid
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(CLK_HZ - 1);
    localparam int HO_W = $clog2(HOLDOVER_MIN + 2) + 1;
    localparam logic [HO_W-1:0] HO_LIM = HO_W'(HOLDOVER_MIN);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // BCD 00..59 increment, returns {carry, value}
    function automatic logic [7:0] bcd_inc60(input logic [6:0] v);
        logic [7:0] r;
        if (v == 7'h59) begin
            r = {1'b1, 7'h00};
        end else if (v[3:0] == 4'd9) begin
            r = {1'b0, v[6:4] + 3'd1, 4'd0};
        end else begin
            r = {1'b0, v[6:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD 00..23 increment with wrap
    function automatic logic [5:0] bcd_inc24(input logic [5:0] v);
        logic [5:0] r;
        if (v == 6'h23) begin
            r = 6'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[5:4] + 2'd1, 4'd0};
        end else begin
            r = {v[5:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [6:0]        r_sec;
    logic [6:0]        r_min;
    logic [5:0]        r_hour;
    logic [21:0]       r_date;
    logic              r_tick;
    logic              r_tv;
    logic [6:0]        r_cand_min;
    logic [5:0]        r_cand_hr;
    logic [HO_W-1:0]   r_hold;
    logic [HO_W-1:0]   w_hold_nxt;
    logic [HO_W-1:0]   w_hold_inc;

    logic [6:0]  w_f_min;
    logic [5:0]  w_f_hr;
    logic [21:0] w_f_date;
    logic [7:0]  w_cand_succ_m;
    logic [5:0]  w_cand_succ_h;
    logic        w_plaus;
    logic        w_load;
    logic        w_div_term;
    logic        w_tick;
    logic        w_roll;
    logic [7:0]  w_sec_inc;
    logic [7:0]  w_min_inc;
    logic [5:0]  w_hour_inc;
    logic        w_unused;

    assign w_f_min  = frame_data[27:21];
    assign w_f_hr   = frame_data[34:29];
    assign w_f_date = {frame_data[57:50], frame_data[49:45],
                       frame_data[44:42], frame_data[41:36]};
    assign w_unused = ^{frame_data[58], frame_data[35],
                        frame_data[28], frame_data[20:0]};

    assign w_cand_succ_m = bcd_inc60(r_cand_min);
    assign w_cand_succ_h = w_cand_succ_m[7] ? bcd_inc24(r_cand_hr)
                                            : r_cand_hr;
    assign w_plaus = !frame_err
                   && (w_f_min == w_cand_succ_m[6:0])
                   && (w_f_hr == w_cand_succ_h);

    // A plausible frame reloads time in every state except UNSYNC
    assign w_load = frame_stb && w_plaus && (r_state != ST_UNSYNC);

    assign w_div_term = (r_div == DIV_TERM);
    assign w_tick     = w_div_term && !w_load;
    assign w_roll     = w_tick && (r_sec == 7'h59);

    assign w_sec_inc  = bcd_inc60(r_sec);
    assign w_min_inc  = bcd_inc60(r_min);
    assign w_hour_inc = bcd_inc24(r_hour);
    assign w_hold_inc = r_hold + 1'b1;

    // Lock FSM next state; strobes take priority over holdover expiry
    always_comb begin
        w_state_nxt = r_state;
        if (frame_stb) begin
            unique case (r_state)
                ST_UNSYNC: begin
                    if (!frame_err) w_state_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_plaus)         w_state_nxt = ST_LOCKED;
                    else if (!frame_err) w_state_nxt = ST_CHECK;
                    else                 w_state_nxt = ST_UNSYNC;
                end
                ST_LOCKED: begin
                    if (w_plaus) w_state_nxt = ST_LOCKED;
                    else         w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_plaus)         w_state_nxt = ST_LOCKED;
                    else if (!frame_err) w_state_nxt = ST_CHECK;
                end
                default: w_state_nxt = ST_UNSYNC;
            endcase
        end else if (r_state == ST_HOLD && w_roll
                     && w_hold_inc >= HO_LIM) begin
            w_state_nxt = ST_UNSYNC;
        end
    end

    // Holdover minutes counted only while staying in HOLD
    always_comb begin
        w_hold_nxt = '0;
        if (w_state_nxt == ST_HOLD) begin
            if (r_state == ST_HOLD && w_roll) w_hold_nxt = w_hold_inc;
            else                              w_hold_nxt = r_hold;
        end
    end

    // State register, validity flag and holdover counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UNSYNC;
            r_tv    <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tv    <= (w_state_nxt == ST_LOCKED)
                    || (w_state_nxt == ST_HOLD);
            r_hold  <= w_hold_nxt;
        end
    end

    // Candidate {hour,min} from every error-free frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_min <= '0;
            r_cand_hr  <= '0;
        end else if (frame_stb && !frame_err) begin
            r_cand_min <= w_f_min;
            r_cand_hr  <= w_f_hr;
        end
    end

    // Local timekeeping: frame load wins over divider tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= '0;
            r_date <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            if (w_load) begin
                r_div  <= '0;
                r_sec  <= 7'h00;
                r_min  <= w_f_min;
                r_hour <= w_f_hr;
                r_date <= w_f_date;
            end else begin
                r_div <= w_div_term ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_sec <= w_sec_inc[6:0];
                    if (w_sec_inc[7]) begin
                        r_min <= w_min_inc[6:0];
                        if (w_min_inc[7]) r_hour <= w_hour_inc;
                    end
                end
            end
        end
    end

    assign sec        = r_sec;
    assign min        = r_min;
    assign hour       = r_hour;
    assign date       = r_date;
    assign sec_tick   = r_tick;
    assign state      = r_state;
    assign time_valid = r_tv;

endmodule

// File: tb/tb_dcf77_sync_ctrl.sv
// Testbench for dcf77_sync_ctrl: randomized frames checked
// against a seconds-of-day reference model.
module tb_dcf77_sync_ctrl;

    localparam int CLK_HZ = 20;
    localparam int HOLDOVER_MIN = 2;
    localparam int S_UNSYNC = 0;
    localparam int S_CHECK  = 1;
    localparam int S_LOCKED = 2;
    localparam int S_HOLD   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_stb = 1'b0;
    logic [58:0] frame_data = '0;
    logic        frame_err = 1'b0;
    logic [6:0]  sec;
    logic [6:0]  min;
    logic [5:0]  hour;
    logic [21:0] date;
    logic        sec_tick;
    logic [1:0]  state;
    logic        time_valid;

    int errors = 0;
    int checks = 0;
    int n_dut_tick = 0;
    int n_mod_tick = 0;

    int          m_state;
    int          m_phase;
    int          m_tod;
    int          m_cand;
    int          m_hold;
    logic [21:0] m_date;
    bit          m_tick;

    always #5 clk = ~clk;

    dcf77_sync_ctrl #(
        .CLK_HZ(CLK_HZ),
        .HOLDOVER_MIN(HOLDOVER_MIN)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_stb(frame_stb),
        .frame_data(frame_data),
        .frame_err(frame_err),
        .sec(sec),
        .min(min),
        .hour(hour),
        .date(date),
        .sec_tick(sec_tick),
        .state(state),
        .time_valid(time_valid)
    );

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic logic [58:0] mk(input int hh, input int mm);
        logic [58:0] f;
        logic [7:0]  b;
        f = 59'({$urandom(), $urandom()});
        b = bcd(mm);
        f[27:21] = b[6:0];
        b = bcd(hh);
        f[34:29] = b[5:0];
        return f;
    endfunction

    function automatic logic [19:0] m_hms();
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] h;
        s = bcd(m_tod % 60);
        m = bcd((m_tod / 60) % 60);
        h = bcd(m_tod / 3600);
        return {s[6:0], m[6:0], h[5:0]};
    endfunction

    function automatic void model_reset();
        m_state = S_UNSYNC;
        m_phase = 0;
        m_tod = 0;
        m_cand = 0;
        m_hold = 0;
        m_date = '0;
        m_tick = 0;
    endfunction

    function automatic void model_clk(input bit stb,
                                      input logic [58:0] d,
                                      input bit e);
        int fm;
        int ns;
        bit ld;
        bit pl;
        ns = m_state;
        ld = 0;
        m_tick = 0;
        fm = (int'(d[34:33]) * 10 + int'(d[32:29])) * 60
           + int'(d[27:25]) * 10 + int'(d[24:21]);
        pl = !e && (fm == (m_cand + 1) % 1440);
        if (stb) begin
            case (m_state)
                S_UNSYNC: if (!e) ns = S_CHECK;
                S_CHECK:  ns = pl ? S_LOCKED : (!e ? S_CHECK : S_UNSYNC);
                S_LOCKED: ns = pl ? S_LOCKED : S_HOLD;
                default:  ns = pl ? S_LOCKED : (!e ? S_CHECK : S_HOLD);
            endcase
            ld = pl && (m_state != S_UNSYNC);
            if (!e) m_cand = fm;
        end
        if (ld) begin
            m_tod = fm * 60;
            m_phase = 0;
            m_date = {d[57:50], d[49:45], d[44:42], d[41:36]};
        end else if (m_phase == CLK_HZ - 1) begin
            m_phase = 0;
            m_tick = 1;
            m_tod = (m_tod + 1) % 86400;
            if (m_tod % 60 == 0 && m_state == S_HOLD) begin
                m_hold++;
                if (!stb && m_hold >= HOLDOVER_MIN) ns = S_UNSYNC;
            end
        end else begin
            m_phase++;
        end
        if (ns != S_HOLD) m_hold = 0;
        m_state = ns;
    endfunction

    task automatic step(input bit stb, input logic [58:0] d,
                        input bit e);
        frame_stb = stb;
        frame_data = d;
        frame_err = e;
        @(posedge clk);
        model_clk(stb, d, e);
        #1;
        frame_stb = 1'b0;
        frame_err = 1'b0;
        if (sec_tick) n_dut_tick++;
        if (m_tick) n_mod_tick++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic do_rst();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({sec, min, hour, date, sec_tick, state, time_valid} !== 46'd0) begin
            errors++;
            $display("FAIL reset: got %h want 0",
                     {sec, min, hour, date, sec_tick, state, time_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        do_rst();
        n_dut_tick = 0;
        idle(3 * CLK_HZ);
        checks++;
        if (n_dut_tick != 3) begin
            errors++;
            $display("FAIL idle_ticks: got %0d want 3", n_dut_tick);
        end
        checks++;
        if ({sec, min, hour} !== {7'h03, 7'h00, 6'h00}) begin
            errors++;
            $display("FAIL idle_time: got %h want %h",
                     {sec, min, hour}, {7'h03, 7'h00, 6'h00});
        end
        checks++;
        if (state !== 2'd0 || time_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: got %0d/%b want 0/0", state, time_valid);
        end
    endtask

    task automatic test_lock();
        idle($urandom_range(3, 30));
        step(1'b1, mk(12, 34), 1'b0);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL lock_check: got %0d want 1", state);
        end
        idle($urandom_range(1, 40));
        step(1'b1, mk(12, 35), 1'b0);
        checks++;
        if ({sec, min, hour} !== {7'h00, 7'h35, 6'h12}) begin
            errors++;
            $display("FAIL lock_time: got %h want %h",
                     {sec, min, hour}, {7'h00, 7'h35, 6'h12});
        end
        checks++;
        if (state !== 2'd2 || time_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_state: got %0d/%b want 2/1", state, time_valid);
        end
        checks++;
        if (date !== m_date) begin
            errors++;
            $display("FAIL lock_date: got %h want %h", date, m_date);
        end
        idle($urandom_range(1, 3 * CLK_HZ));
        checks++;
        if ({sec, min, hour} !== m_hms()) begin
            errors++;
            $display("FAIL lock_run: got %h want %h", {sec, min, hour}, m_hms());
        end
    endtask

    task automatic test_hold_relock();
        idle($urandom_range(1, 20));
        step(1'b1, mk(12, 36), 1'b0);
        checks++;
        if (state !== 2'd2 || min !== 7'h36) begin
            errors++;
            $display("FAIL relock_keep: got %0d/%h want 2/36", state, min);
        end
        idle($urandom_range(1, 20));
        step(1'b1, mk(12, 37), 1'b1);
        checks++;
        if (state !== 2'd3 || time_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_enter: got %0d/%b want 3/1", state, time_valid);
        end
        idle(2 * CLK_HZ + $urandom_range(0, CLK_HZ));
        checks++;
        if ({sec, min, hour} !== m_hms() || state !== 2'd3) begin
            errors++;
            $display("FAIL hold_run: got %h/%0d want %h/3",
                     {sec, min, hour}, state, m_hms());
        end
        step(1'b1, mk(12, 37), 1'b0);
        checks++;
        if (state !== 2'd2 || {sec, min, hour} !== {7'h00, 7'h37, 6'h12}) begin
            errors++;
            $display("FAIL relock: got %0d/%h want 2/%h",
                     state, {sec, min, hour}, {7'h00, 7'h37, 6'h12});
        end
    endtask

    task automatic test_holdover();
        bit done;
        bit bad;
        step(1'b1, mk(12, 38), 1'b1);
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL ho_enter: got %0d want 3", state);
        end
        done = 0;
        bad = 0;
        for (int i = 0; i < 4 * 60 * CLK_HZ && !done; i++) begin
            idle(1);
            if (state !== 2'(m_state)) begin
                bad = 1;
                done = 1;
            end
            if (m_state == S_UNSYNC) done = 1;
        end
        checks++;
        if (bad || m_state != S_UNSYNC) begin
            errors++;
            $display("FAIL ho_timing: got %0d want %0d", state, m_state);
        end
        checks++;
        if (state !== 2'd0 || time_valid !== 1'b0
            || sec !== 7'h00 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL ho_expire: got %0d/%b/%h/%b want 0/0/00/1",
                     state, time_valid, sec, sec_tick);
        end
        idle(CLK_HZ + $urandom_range(0, 10));
        checks++;
        if ({sec, min, hour} !== m_hms() || state !== 2'd0) begin
            errors++;
            $display("FAIL ho_run: got %h want %h", {sec, min, hour}, m_hms());
        end
    endtask

    task automatic test_midnight();
        do_rst();
        step(1'b1, mk(23, 59), 1'b0);
        idle($urandom_range(1, 20));
        step(1'b1, mk(0, 0), 1'b0);
        checks++;
        if (state !== 2'd2 || {sec, min, hour} !== 20'd0) begin
            errors++;
            $display("FAIL mid_lock: got %0d/%h want 2/0", state, {sec, min, hour});
        end
        step(1'b1, mk(23, 58), 1'b0);
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL mid_gap: got %0d want 3", state);
        end
        step(1'b1, mk(23, 59), 1'b0);
        checks++;
        if (state !== 2'd2 || {sec, min, hour} !== {7'h00, 7'h59, 6'h23}) begin
            errors++;
            $display("FAIL mid_load: got %0d/%h want 2/%h",
                     state, {sec, min, hour}, {7'h00, 7'h59, 6'h23});
        end
        idle(60 * CLK_HZ - 1);
        checks++;
        if ({sec, min, hour} !== {7'h59, 7'h59, 6'h23}) begin
            errors++;
            $display("FAIL mid_pre: got %h want %h",
                     {sec, min, hour}, {7'h59, 7'h59, 6'h23});
        end
        idle(1);
        checks++;
        if ({sec, min, hour} !== 20'd0 || sec_tick !== 1'b1) begin
            errors++;
            $display("FAIL mid_wrap: got %h/%b want 0/1", {sec, min, hour}, sec_tick);
        end
    endtask

    task automatic test_candidate();
        do_rst();
        step(1'b1, mk(10, 0), 1'b0);
        idle($urandom_range(1, 10));
        step(1'b1, mk(10, 5), 1'b0);
        checks++;
        if (state !== 2'd1 || time_valid !== 1'b0) begin
            errors++;
            $display("FAIL cand_stay: got %0d/%b want 1/0", state, time_valid);
        end
        idle($urandom_range(1, 10));
        step(1'b1, mk(10, 6), 1'b0);
        checks++;
        if (state !== 2'd2 || {sec, min, hour} !== {7'h00, 7'h06, 6'h10}) begin
            errors++;
            $display("FAIL cand_lock: got %0d/%h want 2/%h",
                     state, {sec, min, hour}, {7'h00, 7'h06, 6'h10});
        end
    endtask

    task automatic test_coincide();
        idle($urandom_range(CLK_HZ, 3 * CLK_HZ));
        for (int i = 0; i < CLK_HZ && m_phase != CLK_HZ - 1; i++) idle(1);
        step(1'b1, mk(10, 7), 1'b0);
        checks++;
        if (sec !== 7'h00 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL coin_load: got %h/%b want 00/0", sec, sec_tick);
        end
        checks++;
        if (state !== 2'd2 || min !== 7'h07) begin
            errors++;
            $display("FAIL coin_state: got %0d/%h want 2/07", state, min);
        end
        n_dut_tick = 0;
        idle(CLK_HZ - 1);
        checks++;
        if (n_dut_tick != 0) begin
            errors++;
            $display("FAIL coin_early: got %0d want 0", n_dut_tick);
        end
        idle(1);
        checks++;
        if (sec_tick !== 1'b1 || sec !== 7'h01) begin
            errors++;
            $display("FAIL coin_next: got %b/%h want 1/01", sec_tick, sec);
        end
    endtask

    task automatic test_reset_mid();
        idle($urandom_range(1, 30));
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sec, min, hour, date, sec_tick, state, time_valid} !== 46'd0) begin
            errors++;
            $display("FAIL rst_mid: got %h want 0",
                     {sec, min, hour, date, sec_tick, state, time_valid});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle($urandom_range(CLK_HZ, 2 * CLK_HZ));
        checks++;
        if ({sec, min, hour} !== m_hms() || state !== 2'd0) begin
            errors++;
            $display("FAIL rst_after: got %h want %h", {sec, min, hour}, m_hms());
        end
    endtask

    task automatic test_random();
        int sel;
        int t;
        bit e;
        do_rst();
        n_dut_tick = 0;
        n_mod_tick = 0;
        for (int k = 0; k < 40; k++) begin
            idle($urandom_range(1, 3 * CLK_HZ));
            sel = $urandom_range(0, 3);
            e = (sel == 0);
            if (sel == 1) t = $urandom_range(0, 1439);
            else          t = (m_cand + 1) % 1440;
            step(1'b1, mk(t / 60, t % 60), e);
            checks++;
            if ({state, time_valid, sec, min, hour, date}
                !== {2'(m_state), m_state >= S_LOCKED, m_hms(), m_date}) begin
                errors++;
                $display("FAIL rand_%0d: got %0d/%b/%h/%h want %0d/%h/%h",
                         k, state, time_valid, {sec, min, hour}, date,
                         m_state, m_hms(), m_date);
            end
        end
        checks++;
        if (n_dut_tick != n_mod_tick) begin
            errors++;
            $display("FAIL rand_ticks: got %0d want %0d", n_dut_tick, n_mod_tick);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_lock();
        test_hold_relock();
        test_holdover();
        test_midnight();
        test_candidate();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
